prefetch_tag_table: RTL and testbench

- Tag store plus lookup/allocate controller for the prefetcher's stream table.
- Holds VEC_SIZE tags with valid bits and drives them into the existing tag-match CAM (findValueIdx).
- Accepts lookup requests over a valid/ready handshake and returns hit, index and allocation result one cycle later.
- On a miss with allocation requested, installs the tag into a free slot, or evicts a round-robin victim when the table is full.

---
 rtl/prefetch_tag_table_pkg.sv | 39 +++
 rtl/findValueIdx.sv | 45 ++++
 rtl/prefetch_tag_table_free_slot_finder.sv | 32 +++
 rtl/prefetch_tag_table.sv | 160 ++++++++++++++++
 tb/tb_prefetch_tag_table.sv | 240 ++++++++++++++++++++++++
 5 files changed

// File: rtl/prefetch_tag_table_pkg.sv
`default_nettype none
// ============================================================================
// Module   : prefetch_tag_table_pkg
// Purpose  : Shared types for the prefetcher stream tag table: tag and index
//            types, the lookup response record and a valid-bit popcount.
// Revision : 1.0 - initial release
// ============================================================================
package prefetch_tag_table_pkg;

    localparam int c_log_vec_size = 4;
    localparam int c_vec_size     = 1 << c_log_vec_size;
    localparam int c_tag_size     = 32;

    typedef logic [c_tag_size-1:0]     tag_t;
    typedef logic [c_log_vec_size-1:0] idx_t;
    typedef logic [c_vec_size-1:0]     vmask_t;
    typedef logic [c_log_vec_size:0]   cnt_t;

    // One lookup result as returned to the consumer.
    typedef struct packed {
        logic hit;
        idx_t idx;
        logic alloc;
        logic evict;
        tag_t evict_tag;
    } rsp_t;

    // Number of set bits in a valid vector (0..c_vec_size).
    function automatic cnt_t popcount(input vmask_t v);
        cnt_t c;
        c = '0;
        for (int i = 0; i < c_vec_size; i++) begin
            c = c + cnt_t'(v[i]);
        end
        return c;
    endfunction

endpackage
`default_nettype wire

// File: rtl/findValueIdx.sv
`default_nettype none
// ============================================================================
// Module   : findValueIdx
// Purpose  : Tag-match CAM. Compares i_value against every valid entry of a
//            flattened tag vector and returns the matching index.
// Ports    : i_vec   - VEC_SIZE tags, entry i at [i*TAG_SIZE +: TAG_SIZE]
//            i_valid - per-entry valid bits
//            i_value - tag to search for
//            o_found - some valid entry matched
//            o_idx   - index of the match (0 when none)
// Revision : 1.0 - initial release
// ============================================================================
module findValueIdx #(
    parameter int LOG_VEC_SIZE = 4,
    parameter int VEC_SIZE     = 1 << LOG_VEC_SIZE,
    parameter int TAG_SIZE     = 32
) (
    input  logic [VEC_SIZE*TAG_SIZE-1:0] i_vec,
    input  logic [VEC_SIZE-1:0]          i_valid,
    input  logic [TAG_SIZE-1:0]          i_value,
    output logic                         o_found,
    output logic [LOG_VEC_SIZE-1:0]      o_idx
);

    logic [VEC_SIZE-1:0] w_match;

    for (genvar i = 0; i < VEC_SIZE; i++) begin : g_cmp
        assign w_match[i] = i_valid[i] && (i_vec[i*TAG_SIZE +: TAG_SIZE] == i_value);
    end

    assign o_found = |w_match;

    // Stored tags are unique, so at most one match bit is set and OR-ing the
    // indices of set bits yields that single index without a priority chain.
    always_comb begin
        o_idx = '0;
        for (int i = 0; i < VEC_SIZE; i++) begin
            if (w_match[i]) begin
                o_idx = o_idx | LOG_VEC_SIZE'(i);
            end
        end
    end

endmodule
`default_nettype wire

// File: rtl/prefetch_tag_table_free_slot_finder.sv
`default_nettype none
// ============================================================================
// Module   : free_slot_finder
// Purpose  : Lowest-index-zero priority encoder over the valid vector.
// Ports    : i_valid     - per-entry valid bits
//            o_idx       - lowest index whose valid bit is 0 (0 when full)
//            o_none_free - every entry is valid
// Revision : 1.0 - initial release
// ============================================================================
module free_slot_finder #(
    parameter int LOG_VEC_SIZE = 4,
    parameter int VEC_SIZE     = 1 << LOG_VEC_SIZE
) (
    input  logic [VEC_SIZE-1:0]     i_valid,
    output logic [LOG_VEC_SIZE-1:0] o_idx,
    output logic                    o_none_free
);

    assign o_none_free = &i_valid;

    // Scan from the top down so the lowest free index is the last one written.
    always_comb begin
        o_idx = '0;
        for (int i = VEC_SIZE - 1; i >= 0; i--) begin
            if (!i_valid[i]) begin
                o_idx = LOG_VEC_SIZE'(i);
            end
        end
    end

endmodule
`default_nettype wire

// File: rtl/prefetch_tag_table.sv
`default_nettype none
// ============================================================================
// Module   : prefetch_tag_table
// Purpose  : Stream-table tag store with lookup / allocate controller.
//            A request is compared against the table combinationally and the
//            result is registered at the accept edge; misses with req_alloc
//            install the tag in the lowest free slot, or evict a round-robin
//            victim when the table is full.
// Ports    : clk, rst                        - clock, sync active-high reset
//            req_valid/req_ready/req_tag/req_alloc - lookup request channel
//            inv_valid/inv_idx               - single-entry invalidate
//            rsp_valid/rsp_ready/rsp_*       - registered response channel
//            occupancy                       - number of valid entries
// Revision : 1.0 - initial release
// ============================================================================
module prefetch_tag_table
    import prefetch_tag_table_pkg::*;
#(
    parameter int LOG_VEC_SIZE = c_log_vec_size,
    parameter int VEC_SIZE     = 1 << LOG_VEC_SIZE,
    parameter int TAG_SIZE     = c_tag_size
) (
    input  logic                    clk,
    input  logic                    rst,
    input  logic                    req_valid,
    output logic                    req_ready,
    input  logic [TAG_SIZE-1:0]     req_tag,
    input  logic                    req_alloc,
    input  logic                    inv_valid,
    input  logic [LOG_VEC_SIZE-1:0] inv_idx,
    output logic                    rsp_valid,
    input  logic                    rsp_ready,
    output logic                    rsp_hit,
    output logic [LOG_VEC_SIZE-1:0] rsp_idx,
    output logic                    rsp_alloc,
    output logic                    rsp_evict,
    output logic [TAG_SIZE-1:0]     rsp_evict_tag,
    output logic [LOG_VEC_SIZE:0]   occupancy
);

    // Table state
    logic [TAG_SIZE-1:0]     r_tags_q [VEC_SIZE];
    logic [TAG_SIZE-1:0]     w_tags_d [VEC_SIZE];
    logic [VEC_SIZE-1:0]     r_valid_q, w_valid_d;
    logic [LOG_VEC_SIZE-1:0] r_rr_ptr_q, w_rr_ptr_d;
    logic [LOG_VEC_SIZE:0]   r_occupancy_q, w_occupancy_d;

    // Response register
    logic                    r_rsp_valid_q, w_rsp_valid_d;
    rsp_t                    r_rsp_q, w_rsp_d;

    // Lookup helpers
    logic [VEC_SIZE*TAG_SIZE-1:0] w_tag_vec;
    logic                         w_match_found;
    logic [LOG_VEC_SIZE-1:0]      w_match_idx;
    logic [LOG_VEC_SIZE-1:0]      w_free_idx;
    logic                         w_table_full;
    logic                         w_accept;
    logic [LOG_VEC_SIZE-1:0]      w_victim;

    for (genvar i = 0; i < VEC_SIZE; i++) begin : g_flat
        assign w_tag_vec[i*TAG_SIZE +: TAG_SIZE] = r_tags_q[i];
    end

    findValueIdx #(
        .LOG_VEC_SIZE (LOG_VEC_SIZE),
        .VEC_SIZE     (VEC_SIZE),
        .TAG_SIZE     (TAG_SIZE)
    ) u_cam (
        .i_vec   (w_tag_vec),
        .i_valid (r_valid_q),
        .i_value (req_tag),
        .o_found (w_match_found),
        .o_idx   (w_match_idx)
    );

    free_slot_finder #(
        .LOG_VEC_SIZE (LOG_VEC_SIZE),
        .VEC_SIZE     (VEC_SIZE)
    ) u_free (
        .i_valid     (r_valid_q),
        .o_idx       (w_free_idx),
        .o_none_free (w_table_full)
    );

    assign req_ready = !r_rsp_valid_q || rsp_ready;
    assign w_accept  = req_valid && req_ready;
    assign w_victim  = w_table_full ? r_rr_ptr_q : w_free_idx;

    always_comb begin
        w_tags_d      = r_tags_q;
        w_valid_d     = r_valid_q;
        w_rr_ptr_d    = r_rr_ptr_q;
        w_rsp_valid_d = r_rsp_valid_q;
        w_rsp_d       = r_rsp_q;

        // Invalidate is applied first so a same-cycle allocation to the same
        // index overrides it and the entry ends valid.
        if (inv_valid) begin
            w_valid_d[inv_idx] = 1'b0;
        end

        if (w_accept) begin
            w_rsp_valid_d     = 1'b1;
            w_rsp_d.hit       = w_match_found;
            w_rsp_d.idx       = '0;
            w_rsp_d.alloc     = 1'b0;
            w_rsp_d.evict     = 1'b0;
            w_rsp_d.evict_tag = '0;
            if (w_match_found) begin
                w_rsp_d.idx = w_match_idx;
            end else if (req_alloc) begin
                w_rsp_d.idx          = w_victim;
                w_rsp_d.alloc        = 1'b1;
                w_tags_d[w_victim]   = req_tag;
                w_valid_d[w_victim]  = 1'b1;
                if (w_table_full) begin
                    w_rsp_d.evict     = 1'b1;
                    w_rsp_d.evict_tag = r_tags_q[r_rr_ptr_q];
                    w_rr_ptr_d        = r_rr_ptr_q + LOG_VEC_SIZE'(1);
                end
            end
        end else if (rsp_ready) begin
            // Response consumed with nothing new behind it; fields are held.
            w_rsp_valid_d = 1'b0;
        end

        w_occupancy_d = popcount(w_valid_d);
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            for (int i = 0; i < VEC_SIZE; i++) begin
                r_tags_q[i] <= '0;
            end
            r_valid_q     <= '0;
            r_rr_ptr_q    <= '0;
            r_occupancy_q <= '0;
            r_rsp_valid_q <= 1'b0;
            r_rsp_q       <= '0;
        end else begin
            r_tags_q      <= w_tags_d;
            r_valid_q     <= w_valid_d;
            r_rr_ptr_q    <= w_rr_ptr_d;
            r_occupancy_q <= w_occupancy_d;
            r_rsp_valid_q <= w_rsp_valid_d;
            r_rsp_q       <= w_rsp_d;
        end
    end

    assign rsp_valid     = r_rsp_valid_q;
    assign rsp_hit       = r_rsp_q.hit;
    assign rsp_idx       = r_rsp_q.idx;
    assign rsp_alloc     = r_rsp_q.alloc;
    assign rsp_evict     = r_rsp_q.evict;
    assign rsp_evict_tag = r_rsp_q.evict_tag;
    assign occupancy     = r_occupancy_q;

endmodule
`default_nettype wire

// File: tb/tb_prefetch_tag_table.sv
`default_nettype none
// ============================================================================
// Module   : tb_prefetch_tag_table
// Purpose  : Self-checking bench for prefetch_tag_table. A table-level model
//            predicts each accepted request's response into a queue; a
//            monitor compares the queue head with whatever the DUT presents.
// Revision : 1.0 - initial release
// ============================================================================
module tb_prefetch_tag_table;

    localparam int LVS = 4;
    localparam int VS  = 1 << LVS;
    localparam int TS  = 32;

    logic           clk = 1'b0;
    logic           rst = 1'b1;
    logic           req_valid = 1'b0;
    logic           req_ready;
    logic [TS-1:0]  req_tag = '0;
    logic           req_alloc = 1'b0;
    logic           inv_valid = 1'b0;
    logic [LVS-1:0] inv_idx = '0;
    logic           rsp_valid;
    logic           rsp_ready = 1'b1;
    logic           rsp_hit;
    logic [LVS-1:0] rsp_idx;
    logic           rsp_alloc;
    logic           rsp_evict;
    logic [TS-1:0]  rsp_evict_tag;
    logic [LVS:0]   occupancy;

    prefetch_tag_table dut (
        .clk           (clk),
        .rst           (rst),
        .req_valid     (req_valid),
        .req_ready     (req_ready),
        .req_tag       (req_tag),
        .req_alloc     (req_alloc),
        .inv_valid     (inv_valid),
        .inv_idx       (inv_idx),
        .rsp_valid     (rsp_valid),
        .rsp_ready     (rsp_ready),
        .rsp_hit       (rsp_hit),
        .rsp_idx       (rsp_idx),
        .rsp_alloc     (rsp_alloc),
        .rsp_evict     (rsp_evict),
        .rsp_evict_tag (rsp_evict_tag),
        .occupancy     (occupancy)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic          hit;
        int            idx;
        logic          alloc;
        logic          evict;
        logic [TS-1:0] evict_tag;
    } exp_t;

    exp_t exp_q[$];

    // Reference model: the table as a plain array of (valid, tag) entries.
    logic [TS-1:0] m_tag   [VS];
    bit            m_valid [VS];
    int            m_rr        = 0;
    bit            m_rsp_valid = 1'b0;

    int checks   = 0;
    int failures = 0;

    task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] req);
        checks++;
        if (act !== req) begin
            failures++;
            $display("FAIL %s actual=%0h required=%0h at %0t", nm, act, req, $time);
        end
    endtask

    function automatic int m_count();
        int c = 0;
        for (int i = 0; i < VS; i++) c += m_valid[i] ? 1 : 0;
        return c;
    endfunction

    initial begin
        for (int i = 0; i < VS; i++) begin
            m_tag[i]   = '0;
            m_valid[i] = 1'b0;
        end
    end

    // Model update on every rising edge from the inputs the DUT also sees.
    always @(posedge clk) begin
        if (rst) begin
            for (int i = 0; i < VS; i++) begin
                m_tag[i]   = '0;
                m_valid[i] = 1'b0;
            end
            m_rr        = 0;
            m_rsp_valid = 1'b0;
            exp_q.delete();
        end else begin
            bit   acc;
            exp_t e;
            int   hit_i, free_i, victim;
            acc    = req_valid && (!m_rsp_valid || rsp_ready);
            hit_i  = -1;
            free_i = -1;
            victim = -1;
            e      = '{hit: 1'b0, idx: 0, alloc: 1'b0, evict: 1'b0, evict_tag: '0};
            if (acc) begin
                for (int i = 0; i < VS; i++)
                    if (m_valid[i] && m_tag[i] == req_tag) hit_i = i;
                for (int i = VS - 1; i >= 0; i--)
                    if (!m_valid[i]) free_i = i;
                if (hit_i >= 0) begin
                    e.hit = 1'b1;
                    e.idx = hit_i;
                end else if (req_alloc) begin
                    e.alloc = 1'b1;
                    if (free_i >= 0) begin
                        victim = free_i;
                    end else begin
                        victim      = m_rr;
                        e.evict     = 1'b1;
                        e.evict_tag = m_tag[m_rr];
                        m_rr        = (m_rr + 1) % VS;
                    end
                    e.idx = victim;
                end
                exp_q.push_back(e);
            end
            if (inv_valid) m_valid[inv_idx] = 1'b0;
            if (victim >= 0) begin
                m_tag[victim]   = req_tag;
                m_valid[victim] = 1'b1;
            end
            if (acc) m_rsp_valid = 1'b1;
            else if (rsp_ready) m_rsp_valid = 1'b0;
        end
    end

    // Monitor: samples mid-cycle, compares the presented response with the
    // queue head and pops it when the consumer takes it.
    always @(negedge clk) begin
        chk("req_ready", 64'(req_ready), 64'(!m_rsp_valid || rsp_ready));
        chk("rsp_valid", 64'(rsp_valid), 64'(m_rsp_valid));
        chk("occupancy", 64'(occupancy), 64'(m_count()));
        if (rsp_valid === 1'b1) begin
            if (exp_q.size() == 0) begin
                checks++;
                failures++;
                $display("FAIL rsp_unexpected actual=rsp_valid=1 required=no pending response at %0t", $time);
            end else begin
                exp_t e;
                e = exp_q[0];
                chk("rsp_hit",       64'(rsp_hit),       64'(e.hit));
                chk("rsp_idx",       64'(rsp_idx),       64'(e.idx));
                chk("rsp_alloc",     64'(rsp_alloc),     64'(e.alloc));
                chk("rsp_evict",     64'(rsp_evict),     64'(e.evict));
                chk("rsp_evict_tag", 64'(rsp_evict_tag), 64'(e.evict_tag));
                if (rsp_ready) void'(exp_q.pop_front());
            end
        end
    end

    // Present one cycle of inputs, then advance past the next rising edge.
    task automatic cyc(input bit v, input logic [TS-1:0] tag, input bit alloc,
                       input bit rdy, input bit iv, input int ii, input bit r = 1'b0);
        rst       = r;
        req_valid = v;
        req_tag   = tag;
        req_alloc = alloc;
        rsp_ready = rdy;
        inv_valid = iv;
        inv_idx   = LVS'(ii);
        @(posedge clk);
        #1;
    endtask

    initial begin
        repeat (2) @(posedge clk);
        #1;
        rst = 1'b0;
        @(negedge clk);
        chk("reset_rsp_fields",
            64'({rsp_hit, rsp_idx, rsp_alloc, rsp_evict, rsp_evict_tag}), 64'(0));
        @(posedge clk);
        #1;

        // Lookup without allocation on an empty table.
        cyc(1, 32'h1234, 0, 1, 0, 0);
        // Fill the table.
        for (int i = 0; i < VS; i++) cyc(1, 32'hA0 + i, 1, 1, 0, 0);
        cyc(1, 32'hA5, 0, 1, 0, 0);
        // Round-robin eviction across all 16 entries, then one more to see the wrap.
        for (int i = 0; i < VS; i++) cyc(1, 32'hB0 + i, 1, 1, 0, 0);
        cyc(1, 32'hC0, 1, 1, 0, 0);
        // Back-to-back: same tag immediately after allocation must hit.
        cyc(1, 32'hC1, 1, 1, 0, 0);
        cyc(1, 32'hC1, 1, 1, 0, 0);

        // Back-pressure for 3 cycles with a request waiting, then release.
        cyc(1, 32'hB5, 0, 0, 0, 0);
        cyc(1, 32'hB5, 0, 0, 0, 0);
        cyc(1, 32'hB5, 0, 0, 0, 0);
        cyc(1, 32'hB5, 0, 1, 0, 0);
        cyc(1, 32'hB6, 0, 1, 0, 0);

        // Free entry 3, then invalidate 3 again while allocating into it.
        cyc(0, 0, 0, 1, 1, 3);
        cyc(1, 32'hD3, 1, 1, 1, 3);
        cyc(1, 32'hD3, 0, 1, 0, 0);
        // Invalidate 7 in the same cycle as a lookup that hits 7.
        cyc(1, m_tag[7], 0, 1, 1, 7);
        cyc(1, m_tag[7], 0, 1, 0, 0);

        // Randomized traffic over a small tag pool so hits and evictions mix.
        for (int n = 0; n < 600; n++) begin
            cyc(($urandom % 4) != 0, 32'h100 + ($urandom % 24), $urandom % 2,
                ($urandom % 4) != 0, ($urandom % 6) == 0, $urandom % VS);
            if (n == 300) begin
                // Mid-stream reset with a response held pending.
                cyc(1, 32'h777, 1, 0, 0, 0);
                cyc(1, 32'h778, 1, 0, 0, 0, 1'b1);
                cyc(1, 32'h999, 1, 1, 0, 0);
            end
        end

        // Drain outstanding responses.
        for (int n = 0; n < 4; n++) cyc(0, 0, 0, 1, 0, 0);
        chk("drain_queue_empty", 64'(exp_q.size()), 64'(0));

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
`default_nettype wire
